trig_clk_mmcm_ctrl: RTL

Sequencer for the trigger-clock MMCM, driving both its dynamic phase-shift port and its DRP port from the USB register domain. It turns register-level commands into MMCM handshakes: multi-step phase shifts, and DRP read or read-modify-write with MMCM reset and relock. The two operations are mutually exclusive. It sits between the trace register block and the trigger clock wizard, in the clk_usb_buf domain.

---
 rtl/trig_clk_pkg.sv | 30 +++
 rtl/cdc_sync_bit.sv | 21 ++
 rtl/trig_clk_mmcm_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/trig_clk_pkg.sv
// Shared types and constants for the trigger-clock MMCM sequencer.
package trig_clk_pkg;

   localparam int DRP_ADDR_W = 7;
   localparam int DRP_DATA_W = 16;

   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_REJECT  = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PS_PULSE,
      ST_PS_WAIT,
      ST_DRP_RST,
      ST_DRP_RD,
      ST_DRP_RWAIT,
      ST_DRP_WR,
      ST_DRP_WWAIT,
      ST_DRP_LOCK
   } mmcm_state_t;

   function automatic logic [DRP_DATA_W-1:0] drp_merge(
      input logic [DRP_DATA_W-1:0] rdata,
      input logic [DRP_DATA_W-1:0] wdata,
      input logic [DRP_DATA_W-1:0] mask
   );
      return (rdata & ~mask) | (wdata & mask);
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single slow level signal.
module cdc_sync_bit (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/trig_clk_mmcm_ctrl.sv
// Trigger-clock MMCM sequencer: multi-step dynamic phase shift and DRP
// read / read-modify-write with MMCM reset and relock.
//
// state        | meaning
// IDLE         | waiting for a go pulse
// PS_PULSE     | psen high for one cycle
// PS_WAIT      | waiting for psdone, then next step or done
// DRP_RST      | RMW only: raise mmcm_reset
// DRP_RD       | den high for one cycle (read)
// DRP_RWAIT    | waiting for drdy with read data
// DRP_WR       | den/dwe high for one cycle with merged data
// DRP_WWAIT    | waiting for drdy after write
// DRP_LOCK     | mmcm_reset released, waiting for relock
module trig_clk_mmcm_ctrl
   import trig_clk_pkg::*;
#(
   parameter int pPS_WIDTH = 16,
   parameter int pTIMEOUT  = 4095,
   parameter int pTO_WIDTH = 12
)(
   input  logic                  usb_clk,
   input  logic                  reset_i,
   input  logic                  I_ps_go,
   input  logic                  I_ps_dir,
   input  logic [pPS_WIDTH-1:0]  I_ps_steps,
   input  logic                  I_drp_go,
   input  logic                  I_drp_wr,
   input  logic [6:0]            I_drp_addr,
   input  logic [15:0]           I_drp_wdata,
   input  logic [15:0]           I_drp_mask,
   input  logic                  I_clear_error,
   output logic                  O_busy,
   output logic [pPS_WIDTH-1:0]  O_ps_position,
   output logic [15:0]           O_drp_rdata,
   output logic [1:0]            O_error,
   output logic                  psen,
   output logic                  psincdec,
   input  logic                  psdone,
   output logic [6:0]            drp_addr,
   output logic                  drp_den,
   output logic                  drp_dwe,
   output logic [15:0]           drp_din,
   input  logic [15:0]           drp_dout,
   input  logic                  drp_drdy,
   output logic                  mmcm_reset,
   input  logic                  locked
);

   localparam logic [pTO_WIDTH-1:0] TO_LOAD = pTO_WIDTH'(pTIMEOUT - 1);

   mmcm_state_t             state;
   logic                    locked_s;
   logic [pPS_WIDTH-1:0]    ps_remaining;
   logic                    drp_wr_l;
   logic [DRP_DATA_W-1:0]   wdata_l;
   logic [DRP_DATA_W-1:0]   mask_l;
   logic [pTO_WIDTH-1:0]    to_cnt;
   logic                    wait_state;
   logic                    wait_evt;
   logic                    timeout_hit;
   logic                    reject;

   cdc_sync_bit u_locked_sync (
      .clk   (usb_clk),
      .reset (reset_i),
      .d     (locked),
      .q     (locked_s)
   );

   always_comb begin
      wait_state = 1'b0;
      wait_evt   = 1'b0;
      case (state)
         ST_PS_WAIT: begin
            wait_state = 1'b1;
            wait_evt   = psdone;
         end
         ST_DRP_RWAIT, ST_DRP_WWAIT: begin
            wait_state = 1'b1;
            wait_evt   = drp_drdy;
         end
         ST_DRP_LOCK: begin
            wait_state = 1'b1;
            wait_evt   = locked_s;
         end
         default: ;
      endcase
      timeout_hit = wait_state && !wait_evt && (to_cnt == '0);
      // DRP has priority over a simultaneous PS request; a zero-step PS is a silent no-op
      if (state != ST_IDLE)
         reject = I_ps_go | I_drp_go;
      else
         reject = (I_ps_go && I_drp_go) ||
                  (I_ps_go && !I_drp_go && (I_ps_steps != '0) && !locked_s);
   end

   always_ff @(posedge usb_clk) begin
      if (reset_i) begin
         state         <= ST_IDLE;
         O_busy        <= 1'b0;
         O_ps_position <= '0;
         O_drp_rdata   <= '0;
         O_error       <= 2'b00;
         psen          <= 1'b0;
         psincdec      <= 1'b0;
         drp_addr      <= '0;
         drp_den       <= 1'b0;
         drp_dwe       <= 1'b0;
         drp_din       <= '0;
         mmcm_reset    <= 1'b0;
         ps_remaining  <= '0;
         drp_wr_l      <= 1'b0;
         wdata_l       <= '0;
         mask_l        <= '0;
         to_cnt        <= TO_LOAD;
      end else begin
         O_error <= (I_clear_error ? 2'b00 : O_error) |
                    (timeout_hit ? ERR_TIMEOUT : 2'b00) |
                    (reject ? ERR_REJECT : 2'b00);
         to_cnt  <= TO_LOAD;
         if (timeout_hit) begin
            state      <= ST_IDLE;
            O_busy     <= 1'b0;
            mmcm_reset <= 1'b0;
            psincdec   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (I_drp_go) begin
                     drp_addr <= I_drp_addr;
                     drp_wr_l <= I_drp_wr;
                     wdata_l  <= I_drp_wdata;
                     mask_l   <= I_drp_mask;
                     O_busy   <= 1'b1;
                     if (I_drp_wr) begin
                        state <= ST_DRP_RST;
                     end else begin
                        drp_den <= 1'b1;
                        state   <= ST_DRP_RD;
                     end
                  end else if (I_ps_go && (I_ps_steps != '0) && locked_s) begin
                     ps_remaining <= I_ps_steps;
                     psincdec     <= I_ps_dir;
                     psen         <= 1'b1;
                     O_busy       <= 1'b1;
                     state        <= ST_PS_PULSE;
                  end
               end
               ST_PS_PULSE: begin
                  psen  <= 1'b0;
                  state <= ST_PS_WAIT;
               end
               ST_PS_WAIT: begin
                  if (psdone) begin
                     O_ps_position <= psincdec ? O_ps_position + 1'b1 : O_ps_position - 1'b1;
                     ps_remaining  <= ps_remaining - 1'b1;
                     if (ps_remaining == pPS_WIDTH'(1)) begin
                        state    <= ST_IDLE;
                        O_busy   <= 1'b0;
                        psincdec <= 1'b0;
                     end else begin
                        psen  <= 1'b1;
                        state <= ST_PS_PULSE;
                     end
                  end else begin
                     to_cnt <= to_cnt - 1'b1;
                  end
               end
               ST_DRP_RST: begin
                  mmcm_reset <= 1'b1;
                  drp_den    <= 1'b1;
                  state      <= ST_DRP_RD;
               end
               ST_DRP_RD: begin
                  drp_den <= 1'b0;
                  state   <= ST_DRP_RWAIT;
               end
               ST_DRP_RWAIT: begin
                  if (drp_drdy) begin
                     O_drp_rdata <= drp_dout;
                     if (drp_wr_l) begin
                        drp_din <= drp_merge(drp_dout, wdata_l, mask_l);
                        drp_den <= 1'b1;
                        drp_dwe <= 1'b1;
                        state   <= ST_DRP_WR;
                     end else begin
                        O_busy <= 1'b0;
                        state  <= ST_IDLE;
                     end
                  end else begin
                     to_cnt <= to_cnt - 1'b1;
                  end
               end
               ST_DRP_WR: begin
                  drp_den <= 1'b0;
                  drp_dwe <= 1'b0;
                  state   <= ST_DRP_WWAIT;
               end
               ST_DRP_WWAIT: begin
                  if (drp_drdy) begin
                     mmcm_reset <= 1'b0;
                     state      <= ST_DRP_LOCK;
                  end else begin
                     to_cnt <= to_cnt - 1'b1;
                  end
               end
               ST_DRP_LOCK: begin
                  // MMCM reset discards any phase offset, so the position restarts at zero
                  if (locked_s) begin
                     O_ps_position <= '0;
                     O_busy        <= 1'b0;
                     state         <= ST_IDLE;
                  end else begin
                     to_cnt <= to_cnt - 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
